// File: rtl/uart_pkg.sv
// Shared definitions for the UART response/command link: packet framing
// constants, transmitter FSM states and the packet checksum.
package uart_pkg;

  localparam logic [7:0]  HdrByte = 8'hA5;
  localparam int unsigned PktLen  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone
  } tx_state_e;

  // Checksum byte B4 over B1..B3; the receiver recomputes it to validate a packet.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] b1,
                                               input logic [7:0] b2,
                                               input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Response transmitter: accepts one {opcode, data} word, frames it as a
// 5-byte packet (header, opcode, data hi, data lo, checksum) and sends each
// byte 8N1, LSB first, back-to-back on uart_tx.
module uart_resp_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned STOP_BITS = 1,
  parameter logic [7:0]  HDR_BYTE  = HdrByte
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [3:0]  rsp_opcode,
  input  logic [15:0] rsp_data,
  output logic        busy,
  output logic        frame_done,
  output logic        uart_tx
);

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  localparam logic [2:0]  ByteLast = 3'(PktLen - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;        // data bit index in StData, stop bit index in StStop
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] data_q, data_d;
  logic        tx_q, tx_d;
  logic        accept;
  logic        div_wrap;
  logic [7:0]  cur_byte;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [3:0]  op,
                                          input logic [15:0] dat);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HDR_BYTE;
      3'd1:    b = {4'h0, op};
      3'd2:    b = dat[15:8];
      3'd3:    b = dat[7:0];
      default: b = pkt_checksum({4'h0, op}, dat[15:8], dat[7:0]);
    endcase
    return b;
  endfunction

  assign accept   = rsp_valid && rsp_ready;
  assign div_wrap = (div_q == DivLast);

  assign rsp_ready  = (state_q == StIdle) || (state_q == StDone);
  assign busy       = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign frame_done = (state_q == StDone);
  assign uart_tx    = tx_q;

  // Packet sequencer: bit timing, byte advance and word capture.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    opcode_d   = opcode_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle, StDone: begin
        // Accepting in StDone gives back-to-back packets with no idle bit.
        if (accept) begin
          state_d    = StStart;
          div_d      = '0;
          bit_d      = '0;
          byte_idx_d = '0;
          opcode_d   = rsp_opcode;
          data_d     = rsp_data;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        if (div_wrap) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      StData: begin
        if (div_wrap) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      StStop: begin
        if (div_wrap) begin
          div_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            if (byte_idx_q == ByteLast) begin
              state_d = StDone;
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
              state_d    = StStart;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the next cycle, derived from next state so the flop lines up with it.
  always_comb begin
    cur_byte = pkt_byte(byte_idx_d, opcode_q, data_q);
    tx_d     = 1'b1;
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = cur_byte[bit_d];
    end
  end

  // State and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      opcode_q   <= '0;
      data_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
    end
  end

endmodule
